l1_mem_arbiter: RTL and testbench
=================================

# l1_mem_arbiter

Round-robin arbiter and transaction sequencer that shares the single main-memory port between the L1 caches, requester 0 being the L1 I-cache and requester 1 the L1 D-cache. It accepts one outstanding transaction per requester, either a line-fill read of `WORDS_PER_LINE` words or a single-word write-through store. It drives the memory-side address/data handshake, forwards returned read words to the granted cache, and signals completion or timeout.

## Interface
- `NUM_REQ`, 2, number of requesters; port 0 is the I-cache, port 1 is the D-cache.
- `WORDS_PER_LINE`, 8, words per line-fill burst.
- `OFFSET_BITS`, 5, byte-offset bits cleared on line-fill addresses.
- `TIMEOUT_CYCLES`, 255, maximum idle cycles waiting on memory before abort; must be at least 1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `REQ_VALID` in NUM_REQ: request pending per requester; held high until that requester's `RSP_DONE`.
- `REQ_WRITE` in NUM_REQ: 1 = single-word store, 0 = line fill.
- `REQ_ADDR` in NUM_REQ*32: byte address; requester i occupies bits [32i+31:32i].
- `REQ_WDATA` in NUM_REQ*32: store data, same packing as `REQ_ADDR`.
- `GRANT` out NUM_REQ: one-hot; high from grant until `RSP_DONE`.
- `RSP_VALID` out 1: `RSP_DATA` holds a line-fill word for the grantee.
- `RSP_WORD` out 3: word index of `RSP_DATA`, 0..WORDS_PER_LINE-1.
- `RSP_DATA` out 32: returned read word.
- `RSP_DONE` out NUM_REQ: one-cycle completion pulse to the grantee.
- `RSP_ERR` out 1: high together with `RSP_DONE` when the transaction timed out.
- `MEM_VALID` out 1: address/command valid toward memory.
- `MEM_WRITE` out 1: command type.
- `MEM_ADDR` out 32: command address.
- `MEM_WDATA` out 32: store data.
- `MEM_READY` in 1: memory accepts the command in any cycle where `MEM_VALID && MEM_READY`.
- `MEM_RVALID` in 1: one read beat, or the write acknowledge.
- `MEM_RDATA` in 32: read beat data.

## Operation
- FSM states: IDLE, CMD, BURST, WACK, DONE.
- IDLE:
  - If any `REQ_VALID` is set, select the first set bit at or after priority pointer `ptr`, searching cyclically.
  - Latch the grantee index, address, write flag and wdata.
  - Assert `GRANT`; go to CMD.
- CMD:
  - Drive `MEM_VALID=1` and `MEM_WRITE` = the latched flag.
  - `MEM_ADDR` = the latched address with `[OFFSET_BITS-1:0]` zeroed for reads, or the full address for writes. `MEM_WDATA` = latched wdata.
  - Hold all command outputs stable until `MEM_READY`.
  - On handshake, go to BURST for a read or WACK for a write.
- BURST:
  - Each `MEM_RVALID` beat registers `MEM_RDATA` to `RSP_DATA` with `RSP_VALID=1` and `RSP_WORD` = beat counter, then increments the counter.
  - After beat WORDS_PER_LINE-1, go to DONE.
  - `MEM_RVALID` may have gaps between beats.
- WACK: the first `MEM_RVALID` goes to DONE; `MEM_RDATA` is ignored.
- DONE:
  - Pulse `RSP_DONE[grantee]` for one cycle.
  - Deassert `GRANT`.
  - Set `ptr` to (grantee+1) mod NUM_REQ.
  - Go to IDLE.
- Watchdog:
  - A counter resets on every state entry and on every beat, and increments otherwise while in CMD, BURST or WACK.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `RSP_ERR=1`. Partial line data already delivered is to be discarded by the cache.
- Input handling:
  - Requests are sampled only in IDLE.
  - A `REQ_VALID` drop mid-transaction is ignored; the transaction runs to completion.
  - `MEM_RVALID` outside BURST or WACK is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - State IDLE, `ptr`=0, beat and watchdog counters 0.
  - Reset asserted mid-transaction returns to IDLE immediately, with no `RSP_DONE` pulse.
- Grant latency: `GRANT` and `MEM_VALID` rise the cycle after `REQ_VALID` is first seen in IDLE.
- `RSP_VALID` rises the cycle after each `MEM_RVALID` beat and lasts exactly one cycle per beat.
- `RSP_DONE` follows the last beat or the write ack by one cycle.
- Back-to-back: a new grant comes earliest 2 cycles after `RSP_DONE` (DONE, then IDLE arbitration).
- Best-case read: 1 cycle grant + 1 cycle CMD + WORDS_PER_LINE beats + 1 cycle DONE.
- Simultaneous requests with `ptr`=0: requester 0 wins; requester 1 wins the next arbitration.

## Structure
- Package `l1_mem_arb_pkg` holds:
  - the state enum;
  - `WORDS_PER_LINE` and `OFFSET_BITS` defaults, shared with the L1 caches;
  - the `addr_line_align` function.
- Sub-module `rr_arbiter`:
  - Inputs: `REQ_VALID`, `ptr`.
  - Output: one-hot grant, found-flag and index.
  - Purely combinational; `ptr` is owned by the parent FSM.

## Test plan
- Single read: requester 1 reads 0x0000_1234, memory returns beats 0xA0..0xA7 with `MEM_READY` after 3 cycles. Required response: `MEM_ADDR`=0x0000_1220 held for 3 cycles, 8 `RSP_VALID` pulses with `RSP_WORD` 0..7, then `RSP_DONE`=2'b10 and `RSP_ERR`=0.
- Store: requester 1 writes 0xDEAD_BEEF to 0x40, write ack after 2 cycles. Required response: `MEM_WRITE`=1, `MEM_ADDR`=0x40, `MEM_WDATA`=0xDEAD_BEEF, `RSP_DONE`=2'b10.
- Contention: both requesters assert in the same cycle from reset. Required response: requester 0 is served first, then requester 1. With both re-requesting continuously, grants alternate 0,1,0,1.
- Beat gaps: `MEM_RVALID` arrives with 1-cycle gaps between beats. Required response: the beat count stays correct and exactly 8 beats are delivered.
- Timeout: `TIMEOUT_CYCLES`=4 and `MEM_READY` never asserts. Required response: `RSP_DONE` and `RSP_ERR` pulse 5 cycles after grant, and the next request is served normally.
- Reset: `RST` is asserted during beat 3 of a read. Required response: all outputs go to 0 asynchronously, no `RSP_DONE`, and the arbiter returns to IDLE with `ptr`=0.

Source files
------------

// File: rtl/l1_mem_arb_pkg.sv
// Shared definitions for the L1 memory-port arbiter and the L1 caches that
// sit in front of it: FSM encoding, line geometry and address alignment.
package l1_mem_arb_pkg;

   // Line geometry shared with the I-cache and D-cache.
   localparam int L1_WORDS_PER_LINE = 8;
   localparam int L1_OFFSET_BITS    = 5;

   // Sequencer states; IDLE is the all-zero encoding so the debug view
   // reads 0 straight out of reset.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_BURST = 3'd2,
      ST_WACK  = 3'd3,
      ST_DONE  = 3'd4
   } arb_state_e;

   // Clear the byte-offset bits so a line fill always starts on a line boundary.
   function automatic logic [31:0] addr_line_align(input logic [31:0] addr,
                                                   input int unsigned off_bits);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << off_bits;
      return addr & mask;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// priority pointer, wrapping around. The pointer itself lives in the parent.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   // Two passes: indices >= ptr first, then the wrapped-around lower indices.
   always_comb begin
      gnt_o   = '0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found_o && req_valid_i[j] && (IDX_W'(j) >= ptr_i)) begin
            found_o  = 1'b1;
            idx_o    = IDX_W'(j);
            gnt_o[j] = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found_o && req_valid_i[j]) begin
            found_o  = 1'b1;
            idx_o    = IDX_W'(j);
            gnt_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares the single main-memory port between the L1 I-cache (requester 0)
// and D-cache (requester 1). One transaction at a time: a line-fill burst
// or a single-word write-through store, with a watchdog that aborts a
// transaction when memory stalls too long.
//
// Handshakes: a command transfers in any cycle with MEM_VALID && MEM_READY;
// the command outputs stay stable until then. Each MEM_RVALID in BURST is
// one read beat, the first MEM_RVALID in WACK is the store acknowledge.
// A requester holds REQ_VALID until it sees its RSP_DONE pulse.
module l1_mem_arbiter
   import l1_mem_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int WORDS_PER_LINE = L1_WORDS_PER_LINE,
   parameter int OFFSET_BITS    = L1_OFFSET_BITS,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NUM_REQ-1:0]    REQ_VALID,
   input  logic [NUM_REQ-1:0]    REQ_WRITE,
   input  logic [NUM_REQ*32-1:0] REQ_ADDR,
   input  logic [NUM_REQ*32-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]    GRANT,
   output logic                  RSP_VALID,
   output logic [2:0]            RSP_WORD,
   output logic [31:0]           RSP_DATA,
   output logic [NUM_REQ-1:0]    RSP_DONE,
   output logic                  RSP_ERR,
   output logic                  MEM_VALID,
   output logic                  MEM_WRITE,
   output logic [31:0]           MEM_ADDR,
   output logic [31:0]           MEM_WDATA,
   input  logic                  MEM_READY,
   input  logic                  MEM_RVALID,
   input  logic [31:0]           MEM_RDATA,
   output logic [2:0]            DBG_STATE
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                write_q, write_d;
   logic [2:0]          beat_q, beat_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                err_q, err_d;
   logic                rsp_valid_q;
   logic [2:0]          rsp_word_q;
   logic [31:0]         rsp_data_q;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic                arb_found;
   logic [IDX_W-1:0]    arb_idx;
   logic [31:0]         sel_addr;
   logic [31:0]         sel_wdata;
   logic                sel_write;
   logic                in_cmd;
   logic                in_txn;
   logic                beat;
   logic                wd_expired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_valid_i (REQ_VALID),
      .ptr_i       (ptr_q),
      .gnt_o       (arb_gnt),
      .found_o     (arb_found),
      .idx_o       (arb_idx)
   );

   // Pick the winning requester's command fields out of the packed buses.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_idx == IDX_W'(k)) begin
            sel_addr  = REQ_ADDR[32*k +: 32];
            sel_wdata = REQ_WDATA[32*k +: 32];
            sel_write = REQ_WRITE[k];
         end
      end
   end

   assign in_cmd     = (state_q == ST_CMD);
   assign in_txn     = (state_q == ST_CMD) || (state_q == ST_BURST) || (state_q == ST_WACK);
   assign beat       = (state_q == ST_BURST) && MEM_RVALID;
   assign wd_expired = (wd_q >= WD_W'(TIMEOUT_CYCLES));

   // Next-state logic: arbitration in IDLE, command/beat sequencing, watchdog.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      beat_d  = beat_q;
      wd_d    = wd_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            wd_d   = '0;
            err_d  = 1'b0;
            if (arb_found) begin
               state_d = ST_CMD;
               idx_d   = arb_idx;
               gnt_d   = arb_gnt;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               write_d = sel_write;
            end
         end
         ST_CMD: begin
            if (MEM_READY) begin
               state_d = write_q ? ST_WACK : ST_BURST;
               wd_d    = '0;
            end else if (wd_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_BURST: begin
            if (MEM_RVALID) begin
               wd_d   = '0;
               beat_d = beat_q + 1'b1;
               if (beat_q == 3'(WORDS_PER_LINE - 1)) begin
                  state_d = ST_DONE;
               end
            end else if (wd_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_WACK: begin
            if (MEM_RVALID) begin
               state_d = ST_DONE;
               wd_d    = '0;
            end else if (wd_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            wd_d    = '0;
            if (idx_q == IDX_W'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and transaction registers; reset abandons any transaction silently.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         beat_q  <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         beat_q  <= beat_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   // Register each read beat toward the grantee for exactly one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rsp_valid_q <= 1'b0;
         rsp_word_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= beat;
         if (beat) begin
            rsp_word_q <= beat_q;
            rsp_data_q <= MEM_RDATA;
         end
      end
   end

   // Outputs decode from registered state only, so reset clears them at once.
   assign GRANT     = in_txn ? gnt_q : '0;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_WORD  = rsp_word_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_DONE  = (state_q == ST_DONE) ? gnt_q : '0;
   assign RSP_ERR   = (state_q == ST_DONE) && err_q;
   assign MEM_VALID = in_cmd;
   assign MEM_WRITE = in_cmd && write_q;
   assign MEM_ADDR  = !in_cmd ? 32'h0 :
                      write_q ? addr_q : addr_line_align(addr_q, OFFSET_BITS);
   assign MEM_WDATA = in_cmd ? wdata_q : 32'h0;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: single read, store, contention,
// beat gaps, watchdog timeout and reset in the middle of a burst.
module tb_l1_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  grant;
  logic        rsp_valid;
  logic [2:0]  rsp_word;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_done;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  l1_mem_arbiter #(
    .NUM_REQ        (2),
    .WORDS_PER_LINE (8),
    .OFFSET_BITS    (5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ_VALID  (req_valid),
    .REQ_WRITE  (req_write),
    .REQ_ADDR   (req_addr),
    .REQ_WDATA  (req_wdata),
    .GRANT      (grant),
    .RSP_VALID  (rsp_valid),
    .RSP_WORD   (rsp_word),
    .RSP_DATA   (rsp_data),
    .RSP_DONE   (rsp_done),
    .RSP_ERR    (rsp_err),
    .MEM_VALID  (mem_valid),
    .MEM_WRITE  (mem_write),
    .MEM_ADDR   (mem_addr),
    .MEM_WDATA  (mem_wdata),
    .MEM_READY  (mem_ready),
    .MEM_RVALID (mem_rvalid),
    .MEM_RDATA  (mem_rdata),
    .DBG_STATE  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    n_tests++; if ({grant, rsp_valid, rsp_done, rsp_err, mem_valid, mem_write} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000000", {grant, rsp_valid, rsp_done, rsp_err, mem_valid, mem_write});
    end
    n_tests++; if ({rsp_word, rsp_data, mem_addr, mem_wdata} !== 99'd0) begin
      n_fail++; $display("FAIL reset_data: got word=%h data=%h addr=%h wdata=%h required 0", rsp_word, rsp_data, mem_addr, mem_wdata);
    end
    n_tests++; if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [2:0]  exp_w;
    logic [31:0] exp_d;
    req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h0000_1234;
    tick();
    n_tests++; if (grant !== 2'b10) begin
      n_fail++; $display("FAIL rd_grant: got %b required 10", grant);
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (!(mem_valid === 1'b1 && mem_write === 1'b0 && mem_addr === 32'h0000_1220)) begin
        n_fail++; $display("FAIL rd_cmd%0d: got valid=%b write=%b addr=%h required 1 0 00001220", c, mem_valid, mem_write, mem_addr);
      end
      if (c == 2) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    n_tests++; if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_cmd_drop: got %b required 0", mem_valid);
    end
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + i;
      tick();
      exp_w = i[2:0]; exp_d = 32'hA0 + i;
      n_tests++; if (!(rsp_valid === 1'b1 && rsp_word === exp_w && rsp_data === exp_d)) begin
        n_fail++; $display("FAIL rd_beat%0d: got v=%b w=%0d d=%h required 1 %0d %h", i, rsp_valid, rsp_word, rsp_data, exp_w, exp_d);
      end
      if (i == 7) begin
        n_tests++; if (!(rsp_done === 2'b10 && rsp_err === 1'b0)) begin
          n_fail++; $display("FAIL rd_done: got done=%b err=%b required 10 0", rsp_done, rsp_err);
        end
      end else begin
        n_tests++; if (rsp_done !== 2'b00) begin
          n_fail++; $display("FAIL rd_early_done%0d: got %b required 00", i, rsp_done);
        end
      end
    end
    mem_rvalid = 1'b0; req_valid = 2'b00;
    tick();
    n_tests++; if (!(grant === 2'b00 && rsp_valid === 1'b0 && rsp_done === 2'b00)) begin
      n_fail++; $display("FAIL rd_idle: got grant=%b v=%b done=%b required 00 0 00", grant, rsp_valid, rsp_done);
    end
  endtask

  task automatic test_store();
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'hDEAD_BEEF;
    tick();
    n_tests++; if (!(mem_valid === 1'b1 && mem_write === 1'b1 && mem_addr === 32'h40 && mem_wdata === 32'hDEAD_BEEF)) begin
      n_fail++; $display("FAIL st_cmd: got v=%b w=%b a=%h d=%h required 1 1 00000040 deadbeef", mem_valid, mem_write, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_tests++; if (!(mem_valid === 1'b0 && grant === 2'b10)) begin
      n_fail++; $display("FAIL st_wack: got v=%b grant=%b required 0 10", mem_valid, grant);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    n_tests++; if (!(rsp_done === 2'b10 && rsp_err === 1'b0 && rsp_valid === 1'b0)) begin
      n_fail++; $display("FAIL st_done: got done=%b err=%b v=%b required 10 0 0", rsp_done, rsp_err, rsp_valid);
    end
    req_valid = 2'b00; req_write = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[31:0] = 32'h0000_0100; req_addr[63:32] = 32'h0000_0208;
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      n_tests++; if (!(grant === exp_g && mem_addr === exp_a)) begin
        n_fail++; $display("FAIL cont_grant%0d: got grant=%b addr=%h required %b %h", t, grant, mem_addr, exp_g, exp_a);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h1000 * t + i;
        tick();
      end
      mem_rvalid = 1'b0;
      n_tests++; if (rsp_done !== exp_g) begin
        n_fail++; $display("FAIL cont_done%0d: got %b required %b", t, rsp_done, exp_g);
      end
      if (t == 3) req_valid = 2'b00;
      tick();
      n_tests++; if (grant !== 2'b00) begin
        n_fail++; $display("FAIL cont_gap%0d: got %b required 00", t, grant);
      end
    end
  endtask

  task automatic test_beat_gaps();
    logic [2:0]  exp_w;
    logic [31:0] exp_d;
    int pulses;
    pulses = 0;
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h0000_03FC;
    tick();
    n_tests++; if (mem_addr !== 32'h0000_03E0) begin
      n_fail++; $display("FAIL gap_addr: got %h required 000003e0", mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0000 + i;
      tick();
      mem_rvalid = 1'b0;
      exp_w = i[2:0]; exp_d = 32'hC0DE_0000 + i;
      if (rsp_valid === 1'b1) pulses++;
      n_tests++; if (!(rsp_valid === 1'b1 && rsp_word === exp_w && rsp_data === exp_d)) begin
        n_fail++; $display("FAIL gap_beat%0d: got v=%b w=%0d d=%h required 1 %0d %h", i, rsp_valid, rsp_word, rsp_data, exp_w, exp_d);
      end
      if (i < 7) begin
        tick();
        if (rsp_valid === 1'b1) pulses++;
        n_tests++; if (!(rsp_valid === 1'b0 && rsp_done === 2'b00)) begin
          n_fail++; $display("FAIL gap_idle%0d: got v=%b done=%b required 0 00", i, rsp_valid, rsp_done);
        end
      end
    end
    n_tests++; if (!(rsp_done === 2'b01 && pulses == 8)) begin
      n_fail++; $display("FAIL gap_done: got done=%b pulses=%0d required 01 8", rsp_done, pulses);
    end
    // a stray beat while in DONE must not produce a response
    mem_rvalid = 1'b1; req_valid = 2'b00;
    tick();
    mem_rvalid = 1'b0;
    n_tests++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL gap_stray: got %b required 0", rsp_valid);
    end
  endtask

  task automatic test_timeout();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h0000_0800;
    mem_ready = 1'b0;
    tick();
    n_tests++; if (grant !== 2'b01) begin
      n_fail++; $display("FAIL to_grant: got %b required 01", grant);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_tests++; if (!(rsp_done === 2'b00 && mem_valid === 1'b1)) begin
        n_fail++; $display("FAIL to_wait%0d: got done=%b v=%b required 00 1", c, rsp_done, mem_valid);
      end
    end
    tick();
    n_tests++; if (!(rsp_done === 2'b01 && rsp_err === 1'b1 && mem_valid === 1'b0)) begin
      n_fail++; $display("FAIL to_abort: got done=%b err=%b v=%b required 01 1 0", rsp_done, rsp_err, mem_valid);
    end
    req_valid = 2'b00;
    tick();
    n_tests++; if (!(rsp_err === 1'b0 && rsp_done === 2'b00)) begin
      n_fail++; $display("FAIL to_clear: got err=%b done=%b required 0 00", rsp_err, rsp_done);
    end
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h80; req_wdata[63:32] = 32'h1234_5678;
    tick();
    n_tests++; if (!(grant === 2'b10 && mem_write === 1'b1 && mem_addr === 32'h80 && mem_wdata === 32'h1234_5678)) begin
      n_fail++; $display("FAIL to_next_cmd: got g=%b w=%b a=%h d=%h required 10 1 00000080 12345678", grant, mem_write, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    n_tests++; if (!(rsp_done === 2'b10 && rsp_err === 1'b0)) begin
      n_fail++; $display("FAIL to_next_done: got done=%b err=%b required 10 0", rsp_done, rsp_err);
    end
    req_valid = 2'b00; req_write = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    // store from requester 0 moves the pointer to 1
    req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h44; req_wdata[31:0] = 32'h55;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    n_tests++; if (rsp_done !== 2'b01) begin
      n_fail++; $display("FAIL rst_pre_store: got %b required 01", rsp_done);
    end
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h100;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hB0 + i;
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hB3;
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({grant, rsp_valid, rsp_done, rsp_err, mem_valid, mem_write} !== 8'h00) begin
      n_fail++; $display("FAIL rst_async_ctrl: got %b required 00000000", {grant, rsp_valid, rsp_done, rsp_err, mem_valid, mem_write});
    end
    n_tests++; if (!(rsp_data === 32'h0 && rsp_word === 3'd0 && mem_addr === 32'h0 && dbg_state === 3'd0)) begin
      n_fail++; $display("FAIL rst_async_data: got d=%h w=%0d a=%h st=%0d required 0", rsp_data, rsp_word, mem_addr, dbg_state);
    end
    mem_rvalid = 1'b0; req_valid = 2'b00;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (!(rsp_done === 2'b00 && grant === 2'b00)) begin
        n_fail++; $display("FAIL rst_no_done%0d: got done=%b grant=%b required 00 00", c, rsp_done, grant);
      end
    end
    // pointer back at 0: requester 0 wins a simultaneous request
    req_valid = 2'b11; req_addr[63:32] = 32'h200;
    tick();
    n_tests++; if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rst_ptr: got %b required 01", grant);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_store();
    test_contention();
    test_beat_gaps();
    test_timeout();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
